// File: rtl/ddr_mux_pkg.sv
// Shared types for the DDR2 MIG frame multiplexer: FSM state encoding, MIG command codes
// and a counter-width helper.
package ddr_mux_pkg;

  typedef enum logic [2:0] {
    StInit   = 3'd0,
    StIdle   = 3'd1,
    StWrData = 3'd2,
    StWrCmd  = 3'd3,
    StRdCmd  = 3'd4,
    StRdWait = 3'd5
  } mux_state_e;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ddr_frame_mux_if.sv
// Bundle of MIG user-interface and frame-logic signals around ddr_frame_mux.
// master = frame logic / MIG side, slave = the multiplexer.
interface ddr_frame_mux_if #(
  parameter int unsigned DATA_W   = 128,
  parameter int unsigned ADDR_W   = 31,
  parameter int unsigned WR_BEATS = 6,
  parameter int unsigned RD_BEATS = 48
);
  logic                         phy_init_done;
  logic                         app_af_afull;
  logic                         app_wdf_afull;
  logic [2:0]                   cmd;
  logic [ADDR_W-1:0]            address;
  logic                         af_we;
  logic                         wdf_we;
  logic [DATA_W-1:0]            w_data;
  logic                         rd_data_valid;
  logic [DATA_W-1:0]            rd_data_fifo_out;
  logic                         write_ram;
  logic [31:0]                  write_address;
  logic [WR_BEATS*DATA_W-1:0]   write_data;
  logic                         write_busy;
  logic                         ask_data;
  logic                         new_frame;
  logic [RD_BEATS*DATA_W-1:0]   read_data;
  logic                         read_done;
  logic [7:0]                   debug;

  modport master (
    output phy_init_done, app_af_afull, app_wdf_afull, rd_data_valid, rd_data_fifo_out,
    output write_ram, write_address, write_data, ask_data, new_frame,
    input  cmd, address, af_we, wdf_we, w_data, write_busy, read_data, read_done, debug
  );

  modport slave (
    input  phy_init_done, app_af_afull, app_wdf_afull, rd_data_valid, rd_data_fifo_out,
    input  write_ram, write_address, write_data, ask_data, new_frame,
    output cmd, address, af_we, wdf_we, w_data, write_busy, read_data, read_done, debug
  );

endinterface

// File: rtl/ddr_rd_collector.sv
// Assembles returned read beats into the wide read_data word, pulses read_done after the
// final beat and flags beats that arrive while no read is outstanding.
module ddr_rd_collector
  import ddr_mux_pkg::*;
#(
  parameter int unsigned DATA_W   = 128,
  parameter int unsigned RD_BEATS = 48
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic                       active_i,
  input  logic                       beat_valid_i,
  input  logic [DATA_W-1:0]          beat_data_i,
  output logic                       last_beat_o,
  output logic [RD_BEATS*DATA_W-1:0] read_data_o,
  output logic                       read_done_o,
  output logic                       stray_o
);

  localparam int unsigned IdxW = cnt_w(RD_BEATS);

  logic [IdxW-1:0]            idx_q;
  logic [RD_BEATS*DATA_W-1:0] data_q;
  logic                       done_q;
  logic                       stray_q;
  logic                       accept;

  assign accept      = beat_valid_i && active_i;
  assign last_beat_o = accept && (idx_q == IdxW'(RD_BEATS - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      stray_q <= 1'b0;
    end else begin
      done_q <= last_beat_o;
      if (start_i) begin
        idx_q <= '0;
      end else if (accept) begin
        idx_q <= last_beat_o ? '0 : idx_q + 1'b1;
      end
      if (accept) begin
        data_q[int'(idx_q)*DATA_W +: DATA_W] <= beat_data_i;
      end
      if (beat_valid_i && !active_i) begin
        stray_q <= 1'b1;
      end
    end
  end

  assign read_data_o = data_q;
  assign read_done_o = done_q;
  assign stray_o     = stray_q;

endmodule

// File: rtl/ddr_frame_mux.sv
// Arbiter between frame logic and the DDR2 MIG user interface: chunked writes, frame-buffer
// reads with read-over-write priority, one-deep request queues and sticky error flags.
module ddr_frame_mux
  import ddr_mux_pkg::*;
#(
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned ADDR_W    = 31,
  parameter int unsigned WR_BEATS  = 6,
  parameter int unsigned RD_BEATS  = 48,
  parameter int unsigned WR_BPC    = 2,
  parameter int unsigned RD_BPC    = 8,
  parameter int unsigned ADDR_STEP = 8
) (
  input  logic           clk0_tb,
  input  logic           rst0_tb,
  ddr_frame_mux_if.slave bus
);

  localparam int unsigned WrCmds = WR_BEATS / WR_BPC;
  localparam int unsigned RdCmds = RD_BEATS / RD_BPC;
  localparam int unsigned WrGrpW = cnt_w(WR_BPC);
  localparam int unsigned WrCmdW = cnt_w(WrCmds);
  localparam int unsigned RdCmdW = cnt_w(RdCmds);
  localparam logic [ADDR_W-1:0] Step = ADDR_W'(ADDR_STEP);

  mux_state_e                 state_q;
  logic                       wdf_we_q, af_we_q;
  logic [2:0]                 cmd_q;
  logic [ADDR_W-1:0]          addr_q;
  logic [DATA_W-1:0]          w_data_q;
  logic                       wr_pend_q, rd_pend_q, rewind_q;
  logic [WR_BEATS*DATA_W-1:0] wr_buf_q, wr_act_q;
  logic [ADDR_W-1:0]          wr_buf_addr_q, wr_addr_q, rd_ptr_q;
  logic [WrGrpW-1:0]          wr_grp_q;
  logic [WrCmdW-1:0]          wr_cmds_q;
  logic [RdCmdW-1:0]          rd_cmds_q;
  logic                       err_wr_q, err_rd_q;

  logic                       rd_req, wr_req, take_rd, take_wr, rd_active;
  logic                       last_beat, stray, read_done;
  logic [RD_BEATS*DATA_W-1:0] read_data;
  logic                       unused_addr_hi;

  assign rd_req    = rd_pend_q | bus.ask_data;
  assign wr_req    = wr_pend_q | bus.write_ram;
  assign take_rd   = (state_q == StIdle) && rd_req;
  assign take_wr   = (state_q == StIdle) && !rd_req && wr_req;
  assign rd_active = (state_q == StRdCmd) || (state_q == StRdWait);

  assign unused_addr_hi = ^bus.write_address[31:ADDR_W];

  always_ff @(posedge clk0_tb or posedge rst0_tb) begin
    if (rst0_tb) begin
      state_q       <= StInit;
      wdf_we_q      <= 1'b0;
      af_we_q       <= 1'b0;
      cmd_q         <= '0;
      addr_q        <= '0;
      w_data_q      <= '0;
      wr_pend_q     <= 1'b0;
      rd_pend_q     <= 1'b0;
      rewind_q      <= 1'b0;
      wr_buf_q      <= '0;
      wr_act_q      <= '0;
      wr_buf_addr_q <= '0;
      wr_addr_q     <= '0;
      rd_ptr_q      <= '0;
      wr_grp_q      <= '0;
      wr_cmds_q     <= '0;
      rd_cmds_q     <= '0;
      err_wr_q      <= 1'b0;
      err_rd_q      <= 1'b0;
    end else begin
      wdf_we_q <= 1'b0;
      af_we_q  <= 1'b0;

      // An older pending request always wins; a newcomer colliding with it is dropped.
      if (bus.write_ram && wr_pend_q) begin
        err_wr_q <= 1'b1;
      end else if (bus.write_ram && !take_wr) begin
        wr_pend_q     <= 1'b1;
        wr_buf_q      <= bus.write_data;
        wr_buf_addr_q <= bus.write_address[ADDR_W-1:0];
      end
      if (take_wr) wr_pend_q <= 1'b0;

      if (bus.ask_data && rd_pend_q) begin
        err_rd_q <= 1'b1;
      end else if (bus.ask_data && !take_rd) begin
        rd_pend_q <= 1'b1;
      end
      if (take_rd) rd_pend_q <= 1'b0;

      case (state_q)
        StInit: begin
          if (bus.phy_init_done) state_q <= StIdle;
        end
        StIdle: begin
          if (take_rd) begin
            state_q   <= StRdCmd;
            rd_cmds_q <= '0;
          end else if (take_wr) begin
            state_q   <= StWrData;
            wr_act_q  <= wr_pend_q ? wr_buf_q : bus.write_data;
            wr_addr_q <= wr_pend_q ? wr_buf_addr_q : bus.write_address[ADDR_W-1:0];
            wr_grp_q  <= '0;
            wr_cmds_q <= '0;
          end
        end
        StWrData: begin
          if (!bus.app_wdf_afull) begin
            wdf_we_q <= 1'b1;
            w_data_q <= wr_act_q[DATA_W-1:0];
            wr_act_q <= wr_act_q >> DATA_W;
            if (wr_grp_q == WrGrpW'(WR_BPC - 1)) begin
              wr_grp_q <= '0;
              state_q  <= StWrCmd;
            end else begin
              wr_grp_q <= wr_grp_q + 1'b1;
            end
          end
        end
        StWrCmd: begin
          if (!bus.app_af_afull) begin
            af_we_q   <= 1'b1;
            cmd_q     <= CMD_WR;
            addr_q    <= wr_addr_q;
            wr_addr_q <= wr_addr_q + Step;
            if (wr_cmds_q == WrCmdW'(WrCmds - 1)) begin
              state_q <= StIdle;
            end else begin
              wr_cmds_q <= wr_cmds_q + 1'b1;
              state_q   <= StWrData;
            end
          end
        end
        StRdCmd: begin
          if (!bus.app_af_afull) begin
            af_we_q  <= 1'b1;
            cmd_q    <= CMD_RD;
            addr_q   <= rd_ptr_q;
            rd_ptr_q <= rd_ptr_q + Step;
            if (rd_cmds_q == RdCmdW'(RdCmds - 1)) begin
              state_q <= StRdWait;
            end else begin
              rd_cmds_q <= rd_cmds_q + 1'b1;
            end
          end
        end
        StRdWait: begin
          if (last_beat) state_q <= StIdle;
        end
        default: state_q <= StInit;
      endcase

      // Rewind is deferred while read commands are still being issued.
      if ((state_q != StRdCmd) && (bus.new_frame || rewind_q)) begin
        rd_ptr_q <= '0;
        rewind_q <= 1'b0;
      end else if (bus.new_frame) begin
        rewind_q <= 1'b1;
      end
    end
  end

  ddr_rd_collector #(
    .DATA_W   (DATA_W),
    .RD_BEATS (RD_BEATS)
  ) u_rd_collector (
    .clk_i        (clk0_tb),
    .rst_i        (rst0_tb),
    .start_i      (take_rd),
    .active_i     (rd_active),
    .beat_valid_i (bus.rd_data_valid),
    .beat_data_i  (bus.rd_data_fifo_out),
    .last_beat_o  (last_beat),
    .read_data_o  (read_data),
    .read_done_o  (read_done),
    .stray_o      (stray)
  );

  assign bus.cmd        = cmd_q;
  assign bus.address    = addr_q;
  assign bus.af_we      = af_we_q;
  assign bus.wdf_we     = wdf_we_q;
  assign bus.w_data     = w_data_q;
  assign bus.write_busy = wr_pend_q || (state_q == StWrData) || (state_q == StWrCmd);
  assign bus.read_data  = read_data;
  assign bus.read_done  = read_done;
  assign bus.debug      = {err_wr_q, err_rd_q, stray, 2'b00, state_q};

endmodule
